// File: rtl/flux_pkg.sv
// Shared types and helpers for the flux round-robin scheduler family.
package flux_pkg;

    // Widest flux count the scheduler and its picker are sized for.
    localparam int MAX_FLUX = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } sched_state_t;

    // Tag width for a given flux count (never narrower than one bit).
    function automatic int tag_width(input int flux);
        return (flux <= 2) ? 1 : $clog2(flux);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: finds the first set request strictly after the
// base index, wrapping modulo FLUX. Rotate, find-first-one, un-rotate.
module rr_priority_pick #(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = $clog2(FLUX)
) (
    input  logic [FLUX-1:0]      req_i,
    input  logic [TAG_WIDTH-1:0] base_i,
    output logic                 valid_o,
    output logic [TAG_WIDTH-1:0] pick_o
);

    localparam logic [TAG_WIDTH:0] FLUX_W = (TAG_WIDTH+1)'(FLUX);

    // (a + b + 1) mod FLUX; one spare bit holds the sum before the wrap.
    function automatic logic [TAG_WIDTH-1:0] wrap_inc_add(
        input logic [TAG_WIDTH-1:0] a,
        input logic [TAG_WIDTH-1:0] b
    );
        logic [TAG_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b} + (TAG_WIDTH+1)'(1);
        if (sum >= FLUX_W) begin
            sum = sum - FLUX_W;
        end
        return sum[TAG_WIDTH-1:0];
    endfunction

    logic [FLUX-1:0]      rot;
    logic [TAG_WIDTH-1:0] off;

    // rot[0] is the request immediately after base, rot[FLUX-1] is base itself.
    for (genvar gi = 0; gi < FLUX; gi++) begin : g_rot
        assign rot[gi] = req_i[wrap_inc_add(base_i, TAG_WIDTH'(gi))];
    end

    // Lowest set bit of the rotated vector is the closest request after base.
    always_comb begin
        valid_o = 1'b0;
        off     = '0;
        for (int j = FLUX - 1; j >= 0; j--) begin
            if (rot[j]) begin
                valid_o = 1'b1;
                off     = TAG_WIDTH'(j);
            end
        end
    end

    assign pick_o = wrap_inc_add(base_i, off);

endmodule

// File: rtl/flux_rr_scheduler.sv
// Round-robin burst scheduler sharing one single-token actor across FLUX
// fluxes. A grant is picked in IDLE, then up to MAX_BURST tokens are moved
// in SERVE; any stall abandons the burst and passes the turn on.
module flux_rr_scheduler
    import flux_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int MAX_BURST = 4,
    parameter int TAG_WIDTH = tag_width(FLUX),
    parameter int CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUX-1:0]      en_mask_i,
    input  logic [FLUX-1:0]      empty_i,
    input  logic [FLUX-1:0]      full_i,
    output logic [FLUX-1:0]      read_o,
    output logic                 write_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 busy_o
);

    localparam logic [TAG_WIDTH-1:0] LAST_RST = TAG_WIDTH'(FLUX - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_BURST - 1);

    sched_state_t         state_q, state_d;
    logic [TAG_WIDTH-1:0] cur_tag_q, cur_tag_d;
    logic [TAG_WIDTH-1:0] last_tag_q, last_tag_d;
    logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;

    logic [FLUX-1:0]      elig;
    logic                 pick_valid;
    logic [TAG_WIDTH-1:0] pick_tag;
    logic                 fire;

    // A flux can move a token only if enabled, has input and has room.
    assign elig = en_mask_i & ~empty_i & ~full_i;

    rr_priority_pick #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_pick (
        .req_i   (elig),
        .base_i  (last_tag_q),
        .valid_o (pick_valid),
        .pick_o  (pick_tag)
    );

    // Next-state, fire decision and strobes; reset suppresses any fire.
    always_comb begin
        state_d     = state_q;
        cur_tag_d   = cur_tag_q;
        last_tag_d  = last_tag_q;
        burst_cnt_d = burst_cnt_q;
        fire        = 1'b0;
        read_o      = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    cur_tag_d   = pick_tag;
                    burst_cnt_d = '0;
                    state_d     = SERVE;
                end
            end
            SERVE: begin
                fire = elig[cur_tag_q] & ~rst;
                if (fire) begin
                    read_o[cur_tag_q] = 1'b1;
                    if (burst_cnt_q == CNT_LAST) begin
                        last_tag_d = cur_tag_q;
                        state_d    = IDLE;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    // Stalled burst is dropped; the turn moves past this flux.
                    last_tag_d = cur_tag_q;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers; last_tag resets so the first search starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_tag_q   <= '0;
            last_tag_q  <= LAST_RST;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_tag_q   <= cur_tag_d;
            last_tag_q  <= last_tag_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign write_o = fire;
    assign tag_o   = cur_tag_q;
    assign busy_o  = (state_q == SERVE);

endmodule
